tdm_demux8_sm: RTL and testbench

//  Receive end of the team's 8-slot time-division serial link: one serial bit per

---
 rtl/tdm_demux8_sm.sv | 127 ++++++++++++
 tb/tb_tdm_demux8_sm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux8_sm.sv
// Receive side of the 8-slot TDM serial link: aligns to frame sync, deserialises
// one bit per valid beat into channels o0..o7 and presents each frame with valid/ack.
module tdm_demux8_sm #(
    parameter bit SYNC_CHECK = 1'b1,
    parameter bit CLR_ON_ERR = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic din_valid,
    input  logic fs,
    input  logic frame_ack,
    output logic o0,
    output logic o1,
    output logic o2,
    output logic o3,
    output logic o4,
    output logic o5,
    output logic o6,
    output logic o7,
    output logic frame_valid,
    output logic overrun,
    output logic sync_err,
    output logic locked
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  slot_q, slot_d;
    logic [6:0]  shreg_q, shreg_d;
    logic [7:0]  frame_q, frame_d;
    logic        frame_valid_q, frame_valid_d;
    logic        overrun_q, overrun_d;
    logic        sync_err_q, sync_err_d;

    logic [6:0]  slot_sel;
    logic        misaligned_fs;

    // One-hot write enable for slots 0..6; slot 7 bypasses the shift register.
    assign slot_sel      = 7'b000_0001 << slot_q;
    assign misaligned_fs = SYNC_CHECK && fs && (slot_q != 3'd0);

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shreg_d       = shreg_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;
        overrun_d     = 1'b0;
        sync_err_d    = 1'b0;

        if (frame_valid_q && frame_ack) begin
            frame_valid_d = 1'b0;
        end

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (fs) begin
                        shreg_d = {6'b0, din};
                        slot_d  = 3'd1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (misaligned_fs) begin
                        sync_err_d = 1'b1;
                        shreg_d    = {6'b0, din};
                        slot_d     = 3'd1;
                        if (CLR_ON_ERR) begin
                            frame_d       = 8'h00;
                            frame_valid_d = 1'b0;
                        end
                    end else if (slot_q == 3'd7) begin
                        frame_d       = {din, shreg_q};
                        frame_valid_d = 1'b1;
                        overrun_d     = frame_valid_q && !frame_ack;
                        shreg_d       = 7'b0;
                        slot_d        = 3'd0;
                    end else begin
                        shreg_d = (shreg_q & ~slot_sel) | (slot_sel & {7{din}});
                        slot_d  = slot_q + 3'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            slot_q        <= 3'd0;
            shreg_q       <= 7'b0;
            frame_q       <= 8'h00;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shreg_q       <= shreg_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign o0          = frame_q[0];
    assign o1          = frame_q[1];
    assign o2          = frame_q[2];
    assign o3          = frame_q[3];
    assign o4          = frame_q[4];
    assign o5          = frame_q[5];
    assign o6          = frame_q[6];
    assign o7          = frame_q[7];
    assign frame_valid = frame_valid_q;
    assign overrun     = overrun_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux8_sm.sv
// Directed bench for tdm_demux8_sm: default build plus a SYNC_CHECK=0 build fed in parallel.
module tb_tdm_demux8_sm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    logic din_valid = 1'b0;
    logic fs = 1'b0;
    logic frame_ack = 1'b0;

    logic a0, a1, a2, a3, a4, a5, a6, a7, a_fv, a_ovr, a_serr, a_lock;
    logic b0, b1, b2, b3, b4, b5, b6, b7, b_fv, b_ovr, b_serr, b_lock;
    logic [7:0] a_outs, b_outs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tdm_demux8_sm dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .fs(fs),
        .frame_ack(frame_ack),
        .o0(a0), .o1(a1), .o2(a2), .o3(a3), .o4(a4), .o5(a5), .o6(a6), .o7(a7),
        .frame_valid(a_fv), .overrun(a_ovr), .sync_err(a_serr), .locked(a_lock)
    );

    tdm_demux8_sm #(.SYNC_CHECK(1'b0), .CLR_ON_ERR(1'b1)) dut_nc (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .fs(fs),
        .frame_ack(frame_ack),
        .o0(b0), .o1(b1), .o2(b2), .o3(b3), .o4(b4), .o5(b5), .o6(b6), .o7(b7),
        .frame_valid(b_fv), .overrun(b_ovr), .sync_err(b_serr), .locked(b_lock)
    );

    assign a_outs = {a7, a6, a5, a4, a3, a2, a1, a0};
    assign b_outs = {b7, b6, b5, b4, b3, b2, b1, b0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
    task automatic send(input logic d, input logic f, input logic ack);
        din       = d;
        fs        = f;
        din_valid = 1'b1;
        frame_ack = ack;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        fs        = 1'b0;
        frame_ack = 1'b0;
        din       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_cycle();
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] v, input logic with_fs);
        for (int i = 0; i < 8; i++) send(v[i], with_fs && (i == 0), 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    logic [7:0] pat;
    logic [6:0] tail;

    initial begin
        #1;
        // 1: reset state, then first aligned frame
        do_reset();
        chk("rst_outs", a_outs, 8'h00);
        chk("rst_fv", a_fv, 1'b0);
        chk("rst_lock", a_lock, 1'b0);
        chk("rst_ovr", a_ovr, 1'b0);
        chk("rst_serr", a_serr, 1'b0);
        pat = 8'b0100_1101;
        for (int i = 0; i < 7; i++) send(pat[i], i == 0, 1'b0);
        chk("t1_fv_before_slot7", a_fv, 1'b0);
        chk("t1_lock", a_lock, 1'b1);
        send(pat[7], 1'b0, 1'b0);
        chk("t1_fv", a_fv, 1'b1);
        chk("t1_outs", a_outs, 8'h4D);
        ack_cycle();
        chk("t1_fv_acked", a_fv, 1'b0);
        chk("t1_outs_hold", a_outs, 8'h4D);

        // 2: unsynchronised beats are discarded
        do_reset();
        for (int i = 0; i < 8; i++) send(1'b1, 1'b0, 1'b0);
        chk("t2_hunt_lock", a_lock, 1'b0);
        chk("t2_hunt_fv", a_fv, 1'b0);
        send_frame(8'h00, 1'b1);
        chk("t2_fv", a_fv, 1'b1);
        chk("t2_outs", a_outs, 8'h00);
        ack_cycle();

        // 3: back-to-back frames without ack, then with ack on completion
        send_frame(8'hA5, 1'b0);
        chk("t3_outs_a5", a_outs, 8'hA5);
        chk("t3_ovr_first", a_ovr, 1'b0);
        send_frame(8'h3C, 1'b1);
        chk("t3_ovr", a_ovr, 1'b1);
        chk("t3_outs_3c", a_outs, 8'h3C);
        chk("t3_fv", a_fv, 1'b1);
        idle(1);
        chk("t3_ovr_1cyc", a_ovr, 1'b0);
        pat = 8'h5A;
        for (int i = 0; i < 7; i++) send(pat[i], 1'b0, 1'b0);
        send(pat[7], 1'b0, 1'b1);
        chk("t3_ack_ovr", a_ovr, 1'b0);
        chk("t3_ack_fv", a_fv, 1'b1);
        chk("t3_ack_outs", a_outs, 8'h5A);
        idle(1);
        chk("t3_fv_kept", a_fv, 1'b1);
        ack_cycle();

        // 4: idle gap inside a frame
        pat = 8'h96;
        for (int i = 0; i < 4; i++) send(pat[i], i == 0, 1'b0);
        idle(3);
        chk("t4_gap_fv", a_fv, 1'b0);
        for (int i = 4; i < 7; i++) send(pat[i], 1'b0, 1'b0);
        chk("t4_fv_early", a_fv, 1'b0);
        send(pat[7], 1'b0, 1'b0);
        chk("t4_fv", a_fv, 1'b1);
        chk("t4_outs", a_outs, 8'h96);

        // 5: fs at slot 5 while a frame is still presented
        for (int i = 0; i < 5; i++) send(1'b1, i == 0, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        chk("t5_serr", a_serr, 1'b1);
        chk("t5_clr_outs", a_outs, 8'h00);
        chk("t5_clr_fv", a_fv, 1'b0);
        chk("t5_nc_serr", b_serr, 1'b0);
        chk("t5_nc_fv", b_fv, 1'b1);
        chk("t5_nc_outs", b_outs, 8'h96);
        tail = 7'b0110010;
        send(tail[0], 1'b0, 1'b0);
        chk("t5_serr_1cyc", a_serr, 1'b0);
        send(tail[1], 1'b0, 1'b0);
        chk("t5_nc_outs_bf", b_outs, 8'hBF);
        chk("t5_nc_ovr", b_ovr, 1'b1);
        chk("t5_fv_pending", a_fv, 1'b0);
        for (int i = 2; i < 6; i++) send(tail[i], 1'b0, 1'b0);
        chk("t5_fv_slot6", a_fv, 1'b0);
        send(tail[6], 1'b0, 1'b0);
        chk("t5_fv", a_fv, 1'b1);
        chk("t5_outs", a_outs, 8'h65);
        chk("t5_ovr", a_ovr, 1'b0);

        // 6: reset mid-frame while a frame is presented
        for (int i = 0; i < 4; i++) send(1'b1, i == 0, 1'b0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("t6_outs", a_outs, 8'h00);
        chk("t6_fv", a_fv, 1'b0);
        chk("t6_lock", a_lock, 1'b0);
        send_frame(8'hFF, 1'b0);
        chk("t6_nofs_fv", a_fv, 1'b0);
        chk("t6_nofs_outs", a_outs, 8'h00);
        chk("t6_nofs_lock", a_lock, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
